uart_rx_fifo: RTL and testbench

Receive-side byte buffer sitting directly downstream of the UART receiver. It captures each byte on the receiver's one-cycle irq pulse and latches frame errors into a sticky flag. It holds up to DEPTH bytes for the CPU/Wishbone register side, which pops them. It raises a level interrupt on a fill threshold or on an idle timeout while data is pending.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_sync_fifo.sv | 53 +++++
 rtl/uart_rx_fifo.sv | 61 ++++++
 tb/tb_uart_rx_fifo.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants for the receiver, its RX FIFO and the future TX FIFO.
package uart_pkg;
   localparam int          UART_OVERSAMPLE = 16;
   localparam int          UART_DATA_W     = 8;
   localparam int          RX_FIFO_DEPTH   = 16;
   localparam int          RX_FIFO_ADDR_W  = $clog2(RX_FIFO_DEPTH);
   localparam logic [31:0] RX_TIMEOUT_CYC  = 32'd4096;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: generic single-clock FIFO with registered 1-cycle read and separate occupancy count.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int W      = UART_DATA_W,
   parameter int DEPTH  = RX_FIFO_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic [W-1:0]    wr_data,
   input  logic            pop,
   output logic [W-1:0]    rd_data,
   output logic            rd_valid,
   output logic            push_ok,
   output logic            pop_ok,
   output logic [ADDR_W:0] count,
   output logic [ADDR_W:0] count_nxt,
   output logic            full,
   output logic            empty
);
   logic [W-1:0]      mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;

   assign empty   = count == '0;
   assign full    = count == (ADDR_W+1)'(DEPTH);
   assign pop_ok  = pop && !empty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign push_ok = push && (!full || pop_ok);

   always_comb
      count_nxt = (push_ok && !pop_ok) ? count + (ADDR_W+1)'(1) :
                  (pop_ok && !push_ok) ? count - (ADDR_W+1)'(1) : count;

   always_ff @(posedge clk)
      if (push_ok) mem[wr_ptr] <= wr_data;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr + ADDR_W'(push_ok);
         rd_ptr   <= rd_ptr + ADDR_W'(pop_ok);
         count    <= count_nxt;
         rd_valid <= pop_ok;
         if (pop_ok) rd_data <= mem[rd_ptr];
      end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte buffer with sticky overrun/frame-error flags, idle timeout
// and a registered level interrupt.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int          DEPTH       = RX_FIFO_DEPTH,
   parameter int          ADDR_W      = $clog2(DEPTH),
   parameter logic [31:0] TIMEOUT_CYC = RX_TIMEOUT_CYC
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rx_valid,
   input  logic [UART_DATA_W-1:0] rx_data,
   input  logic                   rx_frame_err,
   input  logic                   rd_en,
   output logic [UART_DATA_W-1:0] rd_data,
   output logic                   rd_valid,
   input  logic [ADDR_W:0]        thresh,
   input  logic                   clr_err,
   output logic [ADDR_W:0]        count,
   output logic                   empty,
   output logic                   full,
   output logic                   overrun,
   output logic                   frame_err_flag,
   output logic                   irq
);
   logic            push, push_ok, pop_ok, tmo_clr, tmo_flag, tmo_nxt, ov_nxt, fe_nxt;
   logic [31:0]     tmo_cnt, tmo_cnt_nxt;
   logic [ADDR_W:0] count_nxt;

   uart_sync_fifo #(.W(UART_DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
      .clk, .rst_n, .push, .wr_data(rx_data), .pop(rd_en), .rd_data, .rd_valid,
      .push_ok, .pop_ok, .count, .count_nxt, .full, .empty
   );

   // a framed-errored byte is never stored
   assign push = rx_valid && !rx_frame_err;

   always_comb begin
      tmo_clr     = push_ok || pop_ok || empty;
      tmo_cnt_nxt = tmo_clr ? '0 : (tmo_cnt < TIMEOUT_CYC) ? tmo_cnt + 32'd1 : tmo_cnt;
      tmo_nxt     = tmo_clr ? 1'b0 : (tmo_cnt == TIMEOUT_CYC - 32'd1) ? 1'b1 : tmo_flag;
      ov_nxt      = (push && full && !pop_ok) || (overrun && !clr_err);
      fe_nxt      = rx_frame_err || (frame_err_flag && !clr_err);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         tmo_cnt        <= '0;
         tmo_flag       <= 1'b0;
         overrun        <= 1'b0;
         frame_err_flag <= 1'b0;
         irq            <= 1'b0;
      end else begin
         tmo_cnt        <= tmo_cnt_nxt;
         tmo_flag       <= tmo_nxt;
         overrun        <= ov_nxt;
         frame_err_flag <= fe_nxt;
         irq            <= (thresh != '0 && count_nxt >= thresh) || tmo_nxt || ov_nxt || fe_nxt;
      end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed table vectors plus hand sequences for fill/overrun, wrap, timeout and reset.
module tb_uart_rx_fifo;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       rx_valid = 1'b0, rx_frame_err = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
   logic [7:0] rx_data = 8'h00, rd_data;
   logic [4:0] thresh = 5'd0, count;
   logic       rd_valid, empty, full, overrun, frame_err_flag, irq;
   int         checks = 0, errors = 0;

   typedef struct {
      logic [3:0] ctl;    // rx_valid, rx_frame_err, rd_en, clr_err
      logic [7:0] d;
      logic [4:0] th;
      logic [4:0] e_cnt;
      logic [5:0] e_flg;  // empty, full, overrun, frame_err_flag, irq, rd_valid
      logic [7:0] e_rdd;
   } vec_t;
   vec_t vec [19];

   uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .TIMEOUT_CYC(32'd8)) dut (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_frame_err(rx_frame_err), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .thresh(thresh), .clr_err(clr_err), .count(count), .empty(empty), .full(full),
      .overrun(overrun), .frame_err_flag(frame_err_flag), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rx_valid = 1'b0; rx_frame_err = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
   endtask

   initial begin
      vec[0]  = '{4'b1000, 8'h41, 5'd0, 5'd1, 6'b000000, 8'h00};
      vec[1]  = '{4'b1000, 8'h42, 5'd0, 5'd2, 6'b000000, 8'h00};
      vec[2]  = '{4'b1000, 8'h43, 5'd0, 5'd3, 6'b000000, 8'h00};
      vec[3]  = '{4'b0010, 8'h00, 5'd0, 5'd2, 6'b000001, 8'h41};
      vec[4]  = '{4'b0010, 8'h00, 5'd0, 5'd1, 6'b000001, 8'h42};
      vec[5]  = '{4'b0010, 8'h00, 5'd0, 5'd0, 6'b100001, 8'h43};
      vec[6]  = '{4'b0010, 8'h00, 5'd0, 5'd0, 6'b100000, 8'h43};
      vec[7]  = '{4'b1000, 8'h01, 5'd4, 5'd1, 6'b000000, 8'h43};
      vec[8]  = '{4'b1000, 8'h02, 5'd4, 5'd2, 6'b000000, 8'h43};
      vec[9]  = '{4'b1000, 8'h03, 5'd4, 5'd3, 6'b000000, 8'h43};
      vec[10] = '{4'b1000, 8'h04, 5'd4, 5'd4, 6'b000010, 8'h43};
      vec[11] = '{4'b0010, 8'h00, 5'd4, 5'd3, 6'b000001, 8'h01};
      vec[12] = '{4'b0010, 8'h00, 5'd4, 5'd2, 6'b000001, 8'h02};
      vec[13] = '{4'b0010, 8'h00, 5'd4, 5'd1, 6'b000001, 8'h03};
      vec[14] = '{4'b0010, 8'h00, 5'd4, 5'd0, 6'b100001, 8'h04};
      vec[15] = '{4'b1100, 8'h55, 5'd0, 5'd0, 6'b100110, 8'h04};
      vec[16] = '{4'b0001, 8'h00, 5'd0, 5'd0, 6'b100000, 8'h04};
      vec[17] = '{4'b0101, 8'h00, 5'd0, 5'd0, 6'b100110, 8'h04};
      vec[18] = '{4'b0001, 8'h00, 5'd0, 5'd0, 6'b100000, 8'h04};

      #3;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_flags", 32'({full, overrun, frame_err_flag, irq, rd_valid}), 32'd0);
      chk("rst_rdd", 32'(rd_data), 32'd0);
      step();
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         {rx_valid, rx_frame_err, rd_en, clr_err} = vec[i].ctl;
         rx_data = vec[i].d;
         thresh  = vec[i].th;
         step();
         idle();
         chk($sformatf("v%0d_count", i), 32'(count), 32'(vec[i].e_cnt));
         chk($sformatf("v%0d_flags", i),
             32'({empty, full, overrun, frame_err_flag, irq, rd_valid}), 32'(vec[i].e_flg));
         chk($sformatf("v%0d_rdd", i), 32'(rd_data), 32'(vec[i].e_rdd));
      end
      thresh = 5'd0;

      // fill to full, then one more byte overruns and is dropped
      for (int i = 0; i < 16; i++) begin
         rx_valid = 1'b1; rx_data = 8'(i);
         step();
         chk("fill_count", 32'(count), 32'(i + 1));
      end
      idle();
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_irq", 32'({overrun, irq}), 32'd0);
      rx_valid = 1'b1; rx_data = 8'h10;
      step();
      idle();
      chk("ovr_flag", 32'(overrun), 32'd1);
      chk("ovr_irq", 32'(irq), 32'd1);
      chk("ovr_count", 32'(count), 32'd16);
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1;
         step();
         chk("drain_rdv", 32'(rd_valid), 32'd1);
         chk("drain_rdd", 32'(rd_data), 32'(i));
      end
      idle();
      chk("drain_empty", 32'(empty), 32'd1);
      clr_err = 1'b1;
      step();
      idle();
      chk("clr_ovr", 32'({overrun, irq}), 32'd0);

      // full with simultaneous push and pop: no overrun, pushed byte lands after the wrap
      for (int i = 0; i < 16; i++) begin
         rx_valid = 1'b1; rx_data = 8'(8'h80 + i);
         step();
      end
      rx_valid = 1'b1; rx_data = 8'hAA; rd_en = 1'b1;
      step();
      idle();
      chk("pp_count", 32'(count), 32'd16);
      chk("pp_ovr", 32'(overrun), 32'd0);
      chk("pp_full", 32'(full), 32'd1);
      chk("pp_rd", 32'({rd_valid, rd_data}), 32'h180);
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1;
         step();
         chk("wrap_rdd", 32'(rd_data), (i < 15) ? 32'(8'h81 + i) : 32'hAA);
      end
      idle();
      chk("wrap_empty", 32'({empty, irq}), 32'b10);

      // idle timeout with one byte pending
      rx_valid = 1'b1; rx_data = 8'h77;
      step();
      idle();
      chk("tmo_irq0", 32'(irq), 32'd0);
      for (int k = 1; k <= 10; k++) begin
         step();
         chk($sformatf("tmo_irq_k%0d", k), 32'(irq), (k >= 8) ? 32'd1 : 32'd0);
      end
      rd_en = 1'b1;
      step();
      idle();
      chk("tmo_pop", 32'({irq, rd_valid, rd_data}), 32'h177);
      rd_en = 1'b1;
      step();
      idle();
      chk("empty_rd", 32'({rd_valid, rd_data}), 32'h077);

      // asynchronous reset mid-fill with a pop pending
      rx_valid = 1'b1; rx_data = 8'h11;
      step();
      rx_data = 8'h22; rx_frame_err = 1'b1;
      step();
      idle();
      chk("pre_rst", 32'({count, frame_err_flag, irq}), 32'({5'd1, 2'b11}));
      rd_en = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_empty", 32'(empty), 32'd1);
      chk("arst_flags", 32'({full, overrun, frame_err_flag, irq, rd_valid}), 32'd0);
      chk("arst_rdd", 32'(rd_data), 32'd0);
      idle();
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst", 32'({count, empty, rd_valid}), 32'({5'd0, 2'b10}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
